// File: rtl/fmap_read_sequencer_if.sv
// Feature-map scan bus between the layer controller side (start/abort/mode),
// the read sequencer, and the downstream address consumer (valid/ready).
//   master : the sequencer (drives address, tags, status pulses)
//   slave  : the environment (drives start/abort/mode and rd_ready)
interface fmap_read_sequencer_if #(
   parameter int ADDR_WIDTH = 11
);
   logic                  start;
   logic                  abort;
   logic [2:0]            ctrl_mode;
   logic                  rd_ready;
   logic [ADDR_WIDTH-1:0] ctrl_read_addr;
   logic                  rd_valid;
   logic [ADDR_WIDTH-1:0] row_out;
   logic [ADDR_WIDTH-1:0] col_out;
   logic                  busy;
   logic                  done;
   logic                  err_mode;

   modport master (
      input  start, abort, ctrl_mode, rd_ready,
      output ctrl_read_addr, rd_valid, row_out, col_out, busy, done, err_mode
   );

   modport slave (
      output start, abort, ctrl_mode, rd_ready,
      input  ctrl_read_addr, rd_valid, row_out, col_out, busy, done, err_mode
   );
endinterface

// File: rtl/fmap_read_sequencer.sv
// fmap_read_sequencer
//   Generates a row-major raster scan of read addresses over one square
//   feature map, tagged with row/col, under a valid/ready handshake.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high (wins over start/abort)
//   bus  - master modport of fmap_read_sequencer_if:
//          start/abort/ctrl_mode in, rd_ready in,
//          ctrl_read_addr/row_out/col_out/rd_valid out,
//          busy (in RUN), done (pulse after final beat),
//          err_mode (pulse on start with an unsupported mode)
module fmap_read_sequencer #(
   parameter int ADDR_WIDTH        = 11,
   parameter int BASE_ADDR         = 0,
   parameter int FEATURE_MAP1_SIZE = 32,
   parameter int FEATURE_MAP2_SIZE = 28,
   parameter int FEATURE_MAP3_SIZE = 14,
   parameter int FEATURE_MAP4_SIZE = 10,
   parameter int FEATURE_MAP5_SIZE = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   fmap_read_sequencer_if.master bus
);

   // Address is produced incrementally, so the largest map must fit.
   localparam longint unsigned LAST_ADDR =
      longint'(BASE_ADDR) + longint'(FEATURE_MAP1_SIZE) * longint'(FEATURE_MAP1_SIZE) - 64'd1;

   generate
      if (LAST_ADDR >= (64'd1 << ADDR_WIDTH)) begin : g_width_chk
         $error("fmap_read_sequencer: ADDR_WIDTH too small for the largest feature map");
      end
   endgenerate

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] row_q, row_d;
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   // Latched SIZE-1 so the wrap tests are plain equality compares.
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  mode_ok;
   logic [ADDR_WIDTH-1:0] mode_last;
   logic                  beat;
   logic                  col_end;
   logic                  row_end;

   // Map select decode; only consulted when a start is accepted in IDLE.
   always_comb begin
      mode_ok   = 1'b1;
      mode_last = '0;
      case (bus.ctrl_mode)
         3'b000:  mode_last = ADDR_WIDTH'(FEATURE_MAP1_SIZE - 1);
         3'b001:  mode_last = ADDR_WIDTH'(FEATURE_MAP2_SIZE - 1);
         3'b010:  mode_last = ADDR_WIDTH'(FEATURE_MAP3_SIZE - 1);
         3'b011:  mode_last = ADDR_WIDTH'(FEATURE_MAP4_SIZE - 1);
         3'b100:  mode_last = ADDR_WIDTH'(FEATURE_MAP5_SIZE - 1);
         default: mode_ok   = 1'b0;
      endcase
   end

   assign beat    = (state_q == RUN) && bus.rd_ready;
   assign col_end = (col_q == last_q);
   assign row_end = (row_q == last_q);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      col_d   = col_q;
      last_d  = last_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (mode_ok) begin
                  state_d = RUN;
                  last_d  = mode_last;
                  addr_d  = BASE;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         RUN: begin
            // A beat is consumed even when abort arrives with it.
            if (beat) begin
               addr_d = addr_q + ONE;
               if (col_end) begin
                  col_d = '0;
                  row_d = row_q + ONE;
               end else begin
                  col_d = col_q + ONE;
               end
            end
            // Abort outranks the final-beat completion: no done pulse.
            if (bus.abort) begin
               state_d = IDLE;
            end else if (beat && col_end && row_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= BASE;
         row_q   <= '0;
         col_q   <= '0;
         last_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         col_q   <= col_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.ctrl_read_addr = addr_q;
   assign bus.row_out        = row_q;
   assign bus.col_out        = col_q;
   assign bus.rd_valid       = (state_q == RUN);
   assign bus.busy           = (state_q == RUN);
   assign bus.done           = done_q;
   assign bus.err_mode       = err_q;

endmodule

// File: tb/tb_fmap_read_sequencer.sv
// Randomized bench for fmap_read_sequencer. The reference model is the
// beat index k of a scan: expected address BASE+k, row k/SIZE, col k%SIZE,
// and completion once k reaches SIZE*SIZE.
module tb_fmap_read_sequencer;

   localparam int AW   = 11;
   localparam int BASE = 0;
   localparam int SZ [5] = '{32, 28, 14, 10, 5};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   fmap_read_sequencer_if #(.ADDR_WIDTH(AW)) bus();

   fmap_read_sequencer #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"},  32'(bus.ctrl_read_addr), BASE);
      chk({tag, "_row"},   32'(bus.row_out), 0);
      chk({tag, "_col"},   32'(bus.col_out), 0);
      chk({tag, "_valid"}, 32'(bus.rd_valid), 0);
      chk({tag, "_busy"},  32'(bus.busy), 0);
      chk({tag, "_done"},  32'(bus.done), 0);
      chk({tag, "_err"},   32'(bus.err_mode), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         chk("idle_valid", 32'(bus.rd_valid), 0);
         chk("idle_busy",  32'(bus.busy), 0);
         chk("idle_done",  32'(bus.done), 0);
         chk("idle_err",   32'(bus.err_mode), 0);
      end
   endtask

   // One scan of map m. pct: rd_ready probability in percent.
   // abort_at: beat index at which abort is raised (-1 = none).
   // noise: toggle start/ctrl_mode randomly while running.
   // Returns at #1 after the terminating edge, so a following call
   // presents start during the done cycle (back-to-back).
   task automatic run_scan(input int m, input int pct, input int abort_at, input bit noise);
      int s;
      int k;
      int cyc;
      bit rdy;
      bit ab;
      bit fin;
      s   = SZ[m];
      k   = 0;
      cyc = 0;
      fin = 1'b0;
      bus.start     = 1'b1;
      bus.ctrl_mode = 3'(m);
      bus.abort     = 1'b0;
      bus.rd_ready  = 1'b0;
      tick();
      bus.start = 1'b0;
      while (!fin && cyc < 20000) begin
         chk("valid", 32'(bus.rd_valid), 1);
         chk("busy",  32'(bus.busy), 1);
         chk("done",  32'(bus.done), 0);
         chk("err",   32'(bus.err_mode), 0);
         chk("addr",  32'(bus.ctrl_read_addr), BASE + k);
         chk("row",   32'(bus.row_out), k / s);
         chk("col",   32'(bus.col_out), k % s);
         rdy = ($urandom_range(99) < pct);
         ab  = (k == abort_at);
         bus.rd_ready = rdy;
         bus.abort    = ab;
         if (noise) begin
            bus.start     = 1'($urandom_range(1));
            bus.ctrl_mode = 3'($urandom_range(7));
         end
         tick();
         cyc++;
         bus.start    = 1'b0;
         bus.abort    = 1'b0;
         bus.rd_ready = 1'b0;
         if (rdy) k++;
         if (ab) begin
            chk("abort_valid", 32'(bus.rd_valid), 0);
            chk("abort_busy",  32'(bus.busy), 0);
            chk("abort_done",  32'(bus.done), 0);
            fin = 1'b1;
         end else if (k == s * s) begin
            chk("end_done",  32'(bus.done), 1);
            chk("end_valid", 32'(bus.rd_valid), 0);
            chk("end_busy",  32'(bus.busy), 0);
            fin = 1'b1;
         end
      end
      chk("scan_finished", 32'(fin), 1);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.ctrl_mode = 3'b000;
      bus.rd_ready  = 1'b0;
      repeat (3) tick();
      chk_reset("reset");
      rst = 1'b0;
      idle(2);

      // T1, T2: full-rate scans of the smallest and largest maps
      run_scan(4, 100, -1, 1'b0);
      idle(2);
      run_scan(0, 100, -1, 1'b0);
      idle(1);

      // T3: random backpressure
      run_scan(2, 50, -1, 1'b0);
      idle(1);

      // T4: unsupported modes pulse err_mode and stay idle
      for (int m = 5; m < 8; m++) begin
         bus.start     = 1'b1;
         bus.ctrl_mode = 3'(m);
         tick();
         bus.start = 1'b0;
         chk("errm_pulse", 32'(bus.err_mode), 1);
         chk("errm_busy",  32'(bus.busy), 0);
         chk("errm_valid", 32'(bus.rd_valid), 0);
         idle(1);
      end
      run_scan(3, 100, -1, 1'b0);
      idle(1);

      // T5: abort at beat 100, restart from zero, then reset mid-scan
      run_scan(1, 100, 100, 1'b0);
      idle(1);
      run_scan(1, 70, -1, 1'b0);
      idle(1);
      bus.start     = 1'b1;
      bus.ctrl_mode = 3'b001;
      tick();
      bus.start    = 1'b0;
      bus.rd_ready = 1'b1;
      repeat (40) tick();
      chk("pre_rst_busy", 32'(bus.busy), 1);
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      chk_reset("midrst");
      tick();
      chk_reset("midrst2");
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.rd_ready = 1'b0;
      idle(1);

      // Abort on the final beat suppresses done
      run_scan(4, 100, 24, 1'b0);
      idle(1);

      // T6: start/mode noise during RUN, then back-to-back starts
      run_scan(2, 60, -1, 1'b1);
      run_scan(4, 100, -1, 1'b1);
      run_scan(3, 80, -1, 1'b0);
      idle(1);

      // Random scans with random backpressure and occasional aborts
      for (int i = 0; i < 6; i++) begin
         int m;
         int s;
         m = $urandom_range(4);
         s = SZ[m];
         run_scan(m, $urandom_range(100, 30),
                  ($urandom_range(3) == 0) ? int'($urandom_range(s * s - 1)) : -1,
                  1'($urandom_range(1)));
         if ($urandom_range(1) == 1) idle($urandom_range(3, 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
